// File: rtl/fcvt_int_to_float.sv
// fcvt_int_to_float: multicycle int32/uint32 -> IEEE-754 binary32 converter.
// Normalizes one bit per cycle, then rounds to nearest-even in a single step.
module fcvt_int_to_float (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] int_in,
  output logic [31:0] float_out,
  output logic        inexact,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic        sgn_req;   // captured is_signed
  logic        sign;
  logic [31:0] mag;       // holds the raw operand in LOAD, magnitude afterwards
  logic [7:0]  exp;

  logic        ld_sign;
  logic [31:0] ld_mag;
  logic [23:0] m;
  logic        g, s, rnd_up;
  logic [24:0] m_inc;
  logic [22:0] frac;
  logic [7:0]  exp_r;

  // Sign/magnitude split of the captured operand; 0x80000000 negates to itself
  always_comb begin
    ld_sign = sgn_req & mag[31];
    ld_mag  = ld_sign ? (~mag + 32'd1) : mag;
  end

  // Round to nearest-even on the normalized magnitude; carry bumps the exponent
  always_comb begin
    m      = {1'b1, mag[30:8]};
    g      = mag[7];
    s      = |mag[6:0];
    rnd_up = g & (s | m[0]);
    m_inc  = {1'b0, m} + 25'(rnd_up);
    frac   = m_inc[24] ? 23'd0 : m_inc[22:0];
    exp_r  = exp + {7'd0, m_inc[24]};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sgn_req   <= 1'b0;
      sign      <= 1'b0;
      mag       <= 32'd0;
      exp       <= 8'd0;
      float_out <= 32'd0;
      inexact   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= int_in;
            sgn_req <= is_signed;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sign <= ld_sign;
          mag  <= ld_mag;
          exp  <= 8'd158;
          if (ld_mag == 32'd0) begin
            // zero converts to +0 regardless of signedness
            float_out <= 32'd0;
            inexact   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        ROUND: begin
          float_out <= {sign, exp_r, frac};
          inexact   <= g | s;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
